// File: rtl/fdct_pkg.sv
// Shared definitions for the 8x8 forward DCT: datapath widths, FSM encoding,
// cosine coefficient generator and the JPEG zig-zag scan table.
package fdct_pkg;

  localparam int PIX_W  = 9;
  localparam int MID_W  = 14;
  localparam int COEF_W = 12;

  typedef logic [1:0] fdct_state_t;
  localparam fdct_state_t ST_IDLE = 2'd0;
  localparam fdct_state_t ST_ROW  = 2'd1;
  localparam fdct_state_t ST_COL  = 2'd2;
  localparam fdct_state_t ST_DONE = 2'd3;

  // Raster index (8v+u) -> position in the JPEG zig-zag scan.
  localparam logic [5:0] ZZ_POS [64] = '{
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

  // C[k][n] = round(2^frac * c(k)/2 * cos((2n+1)k*pi/16)). The eight distinct
  // magnitudes are held at 2^30 scale and rounded down to the requested precision.
  function automatic int fdct_coef(input int k, input int n, input int frac);
    int m;
    int mag;
    bit neg;
    neg = 1'b0;
    m   = 0;
    if (k == 0) begin
      mag = 379625062;
    end else begin
      m = ((2 * n + 1) * k) % 32;
      if (m > 16) m = 32 - m;
      if (m > 8) begin
        m   = 16 - m;
        neg = 1'b1;
      end
      case (m)
        0:       mag = 536870912;
        1:       mag = 526555088;
        2:       mag = 496004047;
        3:       mag = 446391849;
        4:       mag = 379625062;
        5:       mag = 298269498;
        6:       mag = 205451603;
        7:       mag = 104738319;
        default: mag = 0;
      endcase
    end
    mag = (mag + (1 << (29 - frac))) >>> (30 - frac);
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/fdct_8x8_if.sv
// Block-stream bundle for the forward DCT: pixel block in, coefficient block out.
interface fdct_8x8_if;
  logic         s_valid;
  logic         s_ready;
  logic [511:0] data_in;
  logic         m_valid;
  logic         m_ready;
  logic [767:0] data_out;

  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, data_out
  );

  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, data_out
  );
endinterface

// File: rtl/fdct_1d8.sv
// Combinational 8-point DCT matrix-vector product with two rounded views of the
// same accumulators: a 14-bit intermediate (row pass) and a saturated 12-bit coefficient (column pass).
module fdct_1d8
  import fdct_pkg::*;
#(
  parameter int COEF_FRAC = 12,
  parameter int IN_W      = MID_W,
  parameter int ROW_SH    = COEF_FRAC - 3,
  parameter int COL_SH    = COEF_FRAC + 3
) (
  input  logic signed [IN_W-1:0]   x      [8],
  output logic signed [MID_W-1:0]  y_mid  [8],
  output logic signed [COEF_W-1:0] y_coef [8]
);

  localparam int ACC_W   = 32;
  localparam int RND_MID = 1 << (ROW_SH - 1);
  localparam int RND_COL = 1 << (COL_SH - 1);
  localparam int SAT_MAX = (1 << (COEF_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (COEF_W - 1));

  logic signed [ACC_W-1:0] prod   [8][8];
  logic signed [ACC_W-1:0] acc    [8];
  logic signed [ACC_W-1:0] sh_mid [8];
  logic signed [ACC_W-1:0] sh_col [8];

  for (genvar k = 0; k < 8; k++) begin : g_k
    for (genvar n = 0; n < 8; n++) begin : g_n
      localparam int CKN = fdct_coef(k, n, COEF_FRAC);
      assign prod[k][n] = ACC_W'(CKN) * ACC_W'(x[n]);
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      acc[k] = '0;
      for (int n = 0; n < 8; n++) begin
        acc[k] = acc[k] + prod[k][n];
      end
      sh_mid[k] = (acc[k] + RND_MID) >>> ROW_SH;
      sh_col[k] = (acc[k] + RND_COL) >>> COL_SH;
      y_mid[k]  = sh_mid[k][MID_W-1:0];
      if (sh_col[k] > SAT_MAX) begin
        y_coef[k] = COEF_W'(SAT_MAX);
      end else if (sh_col[k] < SAT_MIN) begin
        y_coef[k] = COEF_W'(SAT_MIN);
      end else begin
        y_coef[k] = sh_col[k][COEF_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fdct_8x8.sv
// 2-D 8x8 forward DCT: level shift, row pass into a transpose buffer, column pass into the output block.
// Build option FDCT_ZIGZAG_EN: coefficients are written in JPEG zig-zag order instead of raster order.
module fdct_8x8
  import fdct_pkg::*;
#(
  parameter int COEF_FRAC = 12
) (
  input  logic      clk,
  input  logic      rst,
  fdct_8x8_if.slave bus
);

  fdct_state_t              state;
  logic [2:0]               cnt;
  logic                     accept;
  logic signed [PIX_W-1:0]  pix    [64];
  logic signed [MID_W-1:0]  tbuf   [64];
  logic signed [COEF_W-1:0] coef_q [64];
  logic signed [MID_W-1:0]  dp_in  [8];
  logic signed [MID_W-1:0]  y_mid  [8];
  logic signed [COEF_W-1:0] y_coef [8];

  function automatic logic [5:0] wr_addr(input logic [2:0] v, input logic [2:0] u);
`ifdef FDCT_ZIGZAG_EN
    return ZZ_POS[{v, u}];
`else
    return {v, u};
`endif
  endfunction

  assign bus.s_ready = (state == ST_IDLE);
  assign bus.m_valid = (state == ST_DONE);
  assign accept      = bus.s_valid && (state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_ROW;
            cnt   <= '0;
          end
        end
        ST_ROW: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= ST_COL;
        end
        ST_COL: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= ST_DONE;
        end
        default: begin
          if (bus.m_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sample and transpose storage is fully rewritten per block, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 64; i++) begin
        pix[i] <= {1'b0, bus.data_in[8*i +: 8]} - 9'd128;
      end
    end
    if (state == ST_ROW) begin
      for (int k = 0; k < 8; k++) begin
        tbuf[{cnt, 3'(k)}] <= y_mid[k];
      end
    end
  end

  // Row pass reads sample row cnt; column pass reads buffer column cnt.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      if (state == ST_COL) begin
        dp_in[n] = tbuf[{3'(n), cnt}];
      end else begin
        dp_in[n] = MID_W'(pix[{cnt, 3'(n)}]);
      end
    end
  end

  fdct_1d8 #(
    .COEF_FRAC (COEF_FRAC),
    .IN_W      (MID_W),
    .ROW_SH    (COEF_FRAC - 3),
    .COL_SH    (COEF_FRAC + 3)
  ) u_dct (
    .x      (dp_in),
    .y_mid  (y_mid),
    .y_coef (y_coef)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) coef_q[i] <= '0;
    end else if (state == ST_COL) begin
      for (int v = 0; v < 8; v++) begin
        coef_q[wr_addr(3'(v), cnt)] <= y_coef[v];
      end
    end
  end

  for (genvar i = 0; i < 64; i++) begin : g_out
    assign bus.data_out[COEF_W*i +: COEF_W] = coef_q[i];
  end

endmodule

// File: doc/fdct_8x8.md
# fdct_8x8

Forward 2-D 8×8 DCT for the encoder path of the JPEG codec. It is the counterpart of the decoder's 2-D IDCT. It accepts one 8×8 block of unsigned 8-bit samples, level-shifts each sample by −128, and runs a row pass followed by a column pass through one shared 8-point DCT datapath. It returns 64 signed 12-bit coefficients to the quantizer stage under a valid/ready handshake.

## Interface
- COEF_FRAC, 12, fractional bits of the fixed-point cosine constants (legal 10..14)
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- s_valid  in  1  input block valid
- s_ready  out  1  block accepted when s_valid & s_ready at a rising edge
- data_in  in  512  pixel (r,c) at data_in[8*(8r+c) +: 8], unsigned
- m_valid  out  1  output block valid; held until accepted
- m_ready  in  1  downstream accepts when m_valid & m_ready
- data_out  out  768  coefficient index i at data_out[12*i +: 12], two's complement

## Operation
- States: IDLE, ROW, COL, DONE.
- IDLE:
  - s_ready=1.
  - On accept, latch all 64 samples minus 128 as 9-bit signed values, clear the counter, and go to ROW.
- ROW:
  - One row per cycle (counter 0..7).
  - y[k] = Σn C[k][n]·x[n], where C[k][n] = round(2^COEF_FRAC · c(k)/2 · cos((2n+1)kπ/16)), c(0)=1/√2, else 1.
  - Result is rounded (add 2^(COEF_FRAC−4), arithmetic shift right COEF_FRAC−3) to 14-bit signed with 3 fractional bits.
  - The result is written to the transpose buffer.
  - Counter 7 → COL.
- COL:
  - One buffer column per cycle (counter 0..7) through the same C.
  - Result is rounded (add 2^(COEF_FRAC+2), arithmetic shift right COEF_FRAC+3) and saturated to [−2048, 2047].
  - The result is written to the output register at vertical frequency v = output row, horizontal frequency u = column.
  - Counter 7 → DONE.
- DONE:
  - m_valid=1, and data_out is stable.
  - On m_ready → IDLE.
- s_ready is high only in IDLE. s_valid in any other state is ignored and the producer must hold.
- Raster index i = 8v+u (DC at index 0).

## Timing
- Reset values:
  - state IDLE
  - s_ready=1
  - m_valid=0
  - data_out=0
  - counter 0
  - transpose buffer contents don't-care
- Reset in any state discards the in-flight block. The first cycle after reset release behaves as IDLE.
- Latency:
  - Acceptance edge E0.
  - Edges E1..E8 write rows; edges E9..E16 write columns.
  - m_valid rises after E16, i.e. 16 cycles after acceptance.
- m_valid is accepted at edge E16+k. s_ready is high from the following cycle. The earliest next acceptance is E16+k+1.
- Minimum block interval is 18 cycles with m_ready tied high.
- data_out only changes during COL writes and on reset. It must not glitch while m_valid=1.
- If m_ready is already high when m_valid rises, the handshake completes at the next edge.

## Configuration
- FDCT_ZIGZAG_EN defined:
  - data_out index i carries the coefficient at JPEG zig-zag position i.
  - Sequence: (v,u)=(0,0),(0,1),(1,0),(2,0),(1,1),(0,2),(0,3),(1,2),…,(7,7).
  - The remap is applied as a fixed permutation of write addresses during COL and adds no latency.
- Undefined: raster order i = 8v+u.

## Structure
- Package fdct_pkg holds:
  - the 8×8 cosine table C as a function of COEF_FRAC
  - the 64-entry zig-zag table
  - widths PIX_W=9, MID_W=14, COEF_W=12
  - the state enum
- Sub-module fdct_1d8:
  - Combinational 8-point matrix-vector multiply.
  - Input width and round/shift amounts are parameters.
  - Instantiated once and shared by ROW and COL through an input mux.
  - The top level holds the FSM, the transpose buffer and the output register.

## Test plan
- All pixels 128 → all 64 coefficients 0. m_valid rises exactly 16 cycles after acceptance.
- All pixels 255 → index 0 = 1016, others 0. All pixels 0 → index 0 = −1024, others 0.
- Pixels 255 for c<4, 0 for c≥4:
  - Raster build: index 0 = −4, nonzero only at indices 1,3,5,7.
  - With FDCT_ZIGZAG_EN: same values at 0,1,6,15,28; all others 0.
- Hold m_ready=0 for 20 cycles in DONE:
  - m_valid and data_out stay constant and s_ready stays 0.
  - A second s_valid block is held and is accepted only the cycle after the m_ready handshake.
- Assert rst during ROW (counter=3) → immediately s_ready=1, m_valid=0, data_out=0. A new all-128 block then yields all zeros.
- Random pixel blocks against a double-precision reference DCT:
  - every coefficient within ±1
  - saturation never exceeded for legal 8-bit input
